// File: rtl/sat_fault_monitor_if.sv
// Health-monitor bus: raw heartbeats and clear in, registered fault indicators out.
interface sat_fault_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       hb;
    logic             clr;
    logic             I1;
    logic             I2;
    logic             I3;
    logic             fault_any;
    logic [CNT_W-1:0] fault_evt;

    modport master (
        output hb,
        output clr,
        input  I1,
        input  I2,
        input  I3,
        input  fault_any,
        input  fault_evt
    );

    modport slave (
        input  hb,
        input  clr,
        output I1,
        output I2,
        output I3,
        output fault_any,
        output fault_evt
    );
endinterface

// File: rtl/sat_fault_monitor.sv
// Heartbeat watchdog feeding the I1/I2/I3 fault levels of sat_fsm.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   OK      | heartbeats arriving in time, indicator low
//   FAULT   | watchdog expired, waiting for the first new heartbeat edge
//   RECOVER | heartbeats resumed, counting timely edges before clearing
//
// The watchdog is a down-counter of cycles remaining; it reloads on every
// edge pulse and a fault is declared when it is already at zero with no edge.
module sat_fault_monitor #(
    parameter int TIMEOUT       = 16,
    parameter int RECOVER_EDGES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sat_fault_monitor_if.slave bus
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int REC_W = (RECOVER_EDGES > 1) ? $clog2(RECOVER_EDGES) : 1;
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_EDGES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       hist_q, hist_d;
    logic [2:0]       edge_pulse;
    logic [2:0]       new_fault;
    state_t           state_q [3];
    state_t           state_d [3];
    logic [WD_W-1:0]  wd_q [3];
    logic [WD_W-1:0]  wd_d [3];
    logic [REC_W-1:0] rec_q [3];
    logic [REC_W-1:0] rec_d [3];
    logic [2:0]       flag_q, flag_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [CNT_W+1:0] evt_sum;

    // State register: synchronisers, channel FSMs, watchdogs and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            for (int c = 0; c < 3; c++) begin
                state_q[c] <= ST_OK;
                wd_q[c]    <= WD_LOAD;
                rec_q[c]   <= '0;
            end
            flag_q <= '0;
            any_q  <= 1'b0;
            evt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            for (int c = 0; c < 3; c++) begin
                state_q[c] <= state_d[c];
                wd_q[c]    <= wd_d[c];
                rec_q[c]   <= rec_d[c];
            end
            flag_q <= flag_d;
            any_q  <= any_d;
            evt_q  <= evt_d;
        end
    end

    // Next state: edge detect, per-channel watchdog FSM, saturating fault count.
    always_comb begin
        sync1_d    = bus.hb;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        edge_pulse = sync2_q ^ hist_q;
        new_fault  = '0;
        for (int c = 0; c < 3; c++) begin
            state_d[c] = state_q[c];
            wd_d[c]    = wd_q[c];
            rec_d[c]   = rec_q[c];
            if (bus.clr) begin
                state_d[c] = ST_OK;
                wd_d[c]    = WD_LOAD;
                rec_d[c]   = '0;
            end else begin
                case (state_q[c])
                    ST_OK: begin
                        if (edge_pulse[c]) begin
                            wd_d[c] = WD_LOAD;
                        end else if (wd_q[c] == '0) begin
                            state_d[c]   = ST_FAULT;
                            wd_d[c]      = WD_LOAD;
                            new_fault[c] = 1'b1;
                        end else begin
                            wd_d[c] = wd_q[c] - WD_W'(1);
                        end
                    end
                    ST_FAULT: begin
                        wd_d[c] = WD_LOAD;
                        if (edge_pulse[c]) begin
                            if (RECOVER_EDGES == 1) begin
                                state_d[c] = ST_OK;
                            end else begin
                                state_d[c] = ST_RECOVER;
                                rec_d[c]   = REC_W'(1);
                            end
                        end
                    end
                    ST_RECOVER: begin
                        if (edge_pulse[c]) begin
                            wd_d[c] = WD_LOAD;
                            if (rec_q[c] == REC_LAST) begin
                                state_d[c] = ST_OK;
                                rec_d[c]   = '0;
                            end else begin
                                rec_d[c] = rec_q[c] + REC_W'(1);
                            end
                        end else if (wd_q[c] == '0) begin
                            // Re-fault while recovering is not a new OK->FAULT event.
                            state_d[c] = ST_FAULT;
                            wd_d[c]    = WD_LOAD;
                            rec_d[c]   = '0;
                        end else begin
                            wd_d[c] = wd_q[c] - WD_W'(1);
                        end
                    end
                    default: begin
                        state_d[c] = ST_OK;
                        wd_d[c]    = WD_LOAD;
                        rec_d[c]   = '0;
                    end
                endcase
            end
        end
        evt_sum = {2'b00, evt_q} + (CNT_W+2)'(new_fault[0])
                + (CNT_W+2)'(new_fault[1]) + (CNT_W+2)'(new_fault[2]);
        if (evt_sum > {2'b00, EVT_MAX}) begin
            evt_d = EVT_MAX;
        end else begin
            evt_d = evt_sum[CNT_W-1:0];
        end
    end

    // Output decode from next state so the indicator flops never see an encoding glitch.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            flag_d[c] = (state_d[c] != ST_OK);
        end
        any_d = |flag_d;
    end

    assign bus.I1        = flag_q[0];
    assign bus.I2        = flag_q[1];
    assign bus.I3        = flag_q[2];
    assign bus.fault_any = any_q;
    assign bus.fault_evt = evt_q;

endmodule
